// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame writer: FSM state encoding
// and the pixel/word geometry of the packed RGB565 stream.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } cam_wr_state_t;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 32;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW  = 4'b0011;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Avalon-MM write-master bus between the frame writer and the frame RAM
// interconnect.
interface cam_frame_writer_if #(
    parameter int ADDR_W = 13
);
    // Handshake: a write completes in the cycle where avm_write is high and
    // avm_waitrequest is low; while stalled the master holds address, data and
    // byteenable stable. avm_chipselect always equals avm_write.
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_byteenable,
        output avm_chipselect,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_byteenable,
        input  avm_chipselect,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );

endinterface

// File: rtl/cam_wr_fifo.sv
// Small synchronous write FIFO; the head entry is read straight from the
// storage registers and forced to zero while empty.
module cam_wr_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         one_left_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full_o     = (cnt_q == CNT_FULL);
    assign empty_o    = (cnt_q == '0);
    assign one_left_o = (cnt_q == (PW+1)'(1));

    // A push into a full FIFO is still taken when the head leaves this cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Packs the RGB565 camera stream two pixels per word and writes each frame
// into the frame RAM through an Avalon-MM write master behind a small FIFO.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len_words,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 pix_sof,
    input  logic                 pix_eof,
    cam_frame_writer_if.master   avm,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_W:0]      words_written,
    output cam_wr_state_t        dbg_state
);

    localparam int ENTRY_W = ADDR_W + 4 + WORD_W;

    cam_wr_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   k_q, k_d, k_inc;
    logic              half_q, half_d;
    logic [PIX_W-1:0]  lo_q, lo_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;

    logic               push, pop, pix_acc;
    logic [3:0]         push_be;
    logic [WORD_W-1:0]  push_data;
    logic [ADDR_W-1:0]  push_addr;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty, fifo_one;

    cam_wr_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .din_i      ({push_addr, push_be, push_data}),
        .pop_i      (pop),
        .dout_o     (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .one_left_o (fifo_one)
    );

    assign avm.avm_address    = fifo_dout[ENTRY_W-1 -: ADDR_W];
    assign avm.avm_byteenable = fifo_dout[WORD_W+3 -: 4];
    assign avm.avm_writedata  = fifo_dout[WORD_W-1:0];
    assign avm.avm_write      = ~fifo_empty;
    assign avm.avm_chipselect = ~fifo_empty;

    assign pop       = ~fifo_empty & ~avm.avm_waitrequest;
    assign k_inc     = k_q + 1'b1;
    assign push_addr = base_q + k_q[ADDR_W-1:0];
    assign pix_acc   = pix_valid & (((state_q == ST_ARMED) & pix_sof) | (state_q == ST_CAPTURE));

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        k_d       = k_q;
        half_d    = half_q;
        lo_d      = lo_q;
        ovf_d     = ovf_q;
        words_d   = pop ? words_q + 1'b1 : words_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_be   = BE_FULL;
        push_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len_words;
                    ovf_d   = 1'b0;
                    words_d = '0;
                    k_d     = '0;
                    half_d  = 1'b0;
                    state_d = (len_words == '0) ? ST_FLUSH : ST_ARMED;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (pix_acc) begin
                    state_d = ST_CAPTURE;
                    if (half_q) begin
                        push      = 1'b1;
                        push_data = {pix_data, lo_q};
                        half_d    = 1'b0;
                    end else if (pix_eof) begin
                        push      = 1'b1;
                        push_be   = BE_LOW;
                        push_data = {{PIX_W{1'b0}}, pix_data};
                    end else begin
                        half_d = 1'b1;
                        lo_d   = pix_data;
                    end
                    // A dropped word still advances k so later words land at their own address.
                    if (push) k_d = k_inc;
                    if (pix_eof || (push && (k_inc == len_q))) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty || (fifo_one && pop)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            half_q  <= 1'b0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            words_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            words_q <= words_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign words_written = words_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed self-checking bench for cam_frame_writer: pixel driver tasks, an
// Avalon write monitor against an expected-write queue, and a summary line.
module tb_cam_frame_writer;
  import cam_pkg::*;

  localparam int ADDR_W     = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = ADDR_W + 4 + 32;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     len_words = '0;
  logic                pix_valid = 1'b0;
  logic [15:0]         pix_data = '0;
  logic                pix_sof = 1'b0;
  logic                pix_eof = 1'b0;
  logic                busy, done, overflow;
  logic [ADDR_W:0]     words_written;
  cam_wr_state_t       dbg_state;

  cam_frame_writer_if #(.ADDR_W(ADDR_W)) avm ();

  cam_frame_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .len_words     (len_words),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eof       (pix_eof),
    .avm           (avm),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, got running want finished");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  logic busy_at_done = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Avalon write monitor, sampled on the falling edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (avm.avm_write && !avm.avm_waitrequest) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          check("wr_cs", 64'(avm.avm_chipselect), 64'd1);
          check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(avm.avm_address), 64'(e[EW-1 -: ADDR_W]));
            check("wr_be", 64'(avm.avm_byteenable), 64'(e[35:32]));
            check("wr_data", 64'(avm.avm_writedata), 64'(e[31:0]));
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  // driver tasks; each returns 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    base_addr = b;
    len_words = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pix(input logic [15:0] d, input logic s, input logic e);
    pix_valid = 1'b1;
    pix_data = d;
    pix_sof = s;
    pix_eof = e;
    step();
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_eof = 1'b0;
  endtask

  task automatic exp_add(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_q.push_back({a, be, d});
  endtask

  task automatic wait_done(input int snap, input string tag);
    int n = 0;
    while (done_cnt == snap && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != snap), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // directed stimulus
  initial begin
    int snap;
    int w0;
    avm.avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", 64'(avm.avm_write), 64'd0);
    check("rst_cs", 64'(avm.avm_chipselect), 64'd0);
    check("rst_addr", 64'(avm.avm_address), 64'd0);
    check("rst_data", 64'(avm.avm_writedata), 64'd0);
    check("rst_be", 64'(avm.avm_byteenable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ww", 64'(words_written), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    step();

    // basic 4-word frame; junk before sof is discarded
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h0100, 14'd4);
    check("t1_busy_armed", 64'(busy), 64'd1);
    pix(16'hDEAD, 1'b0, 1'b0);
    pix(16'hBEEF, 1'b0, 1'b1);
    exp_add(13'h0100, 4'hF, 32'h0002_0001);
    exp_add(13'h0101, 4'hF, 32'h0004_0003);
    exp_add(13'h0102, 4'hF, 32'h0006_0005);
    exp_add(13'h0103, 4'hF, 32'h0008_0007);
    for (int i = 1; i <= 8; i++) pix(16'(i), i == 1, i == 8);
    wait_done(snap, "t1");
    check("t1_done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("t1_ww", 64'(words_written), 64'd4);
    check("t1_wr_cnt", 64'(wr_cnt - w0), 64'd4);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // odd pixel count: trailing half word
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h0040, 14'd8);
    exp_add(13'h0040, 4'hF, 32'h0002_0001);
    exp_add(13'h0041, 4'h3, 32'h0000_0003);
    pix(16'h0001, 1'b1, 1'b0);
    pix(16'h0002, 1'b0, 1'b0);
    pix(16'h0003, 1'b0, 1'b1);
    wait_done(snap, "t2");
    idle(4);
    check("t2_ww", 64'(words_written), 64'd2);
    check("t2_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // address wrap, stopped by the length limit
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h1FFF, 14'd3);
    exp_add(13'h1FFF, 4'hF, 32'h00A2_00A1);
    exp_add(13'h0000, 4'hF, 32'h00A4_00A3);
    exp_add(13'h0001, 4'hF, 32'h00A6_00A5);
    for (int i = 1; i <= 6; i++) pix(16'(16'h00A0 + i), i == 1, 1'b0);
    wait_done(snap, "t3");
    check("t3_ww", 64'(words_written), 64'd3);
    check("t3_wr_cnt", 64'(wr_cnt - w0), 64'd3);

    // limit 2 with a 10-pixel frame
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h0200, 14'd2);
    exp_add(13'h0200, 4'hF, 32'h00B1_00B0);
    exp_add(13'h0201, 4'hF, 32'h00B3_00B2);
    for (int i = 0; i < 10; i++) pix(16'(16'h00B0 + i), i == 0, i == 9);
    wait_done(snap, "t4");
    idle(3);
    check("t4_ww", 64'(words_written), 64'd2);
    check("t4_wr_cnt", 64'(wr_cnt - w0), 64'd2);
    check("t4_busy", 64'(busy), 64'd0);

    // zero-length frame
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h0300, 14'd0);
    wait_done(snap, "t5");
    idle(2);
    check("t5_ww", 64'(words_written), 64'd0);
    check("t5_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // 20-cycle stall during a 16-pixel burst, then two more words
    snap = done_cnt;
    w0 = wr_cnt;
    do_start(13'h0300, 14'd16);
    exp_add(13'h0300, 4'hF, 32'h00C1_00C0);
    exp_add(13'h0301, 4'hF, 32'h00C3_00C2);
    exp_add(13'h0302, 4'hF, 32'h00C5_00C4);
    exp_add(13'h0303, 4'hF, 32'h00C7_00C6);
    exp_add(13'h0308, 4'hF, 32'h00D1_00D0);
    exp_add(13'h0309, 4'hF, 32'h00D3_00D2);
    avm.avm_waitrequest = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) pix(16'(16'h00C0 + i), i == 0, 1'b0);
      end
      begin
        idle(20);
        avm.avm_waitrequest = 1'b0;
      end
    join
    check("t6_ovf", 64'(overflow), 64'd1);
    check("t6_no_wr_stalled", 64'(wr_cnt - w0), 64'd0);
    idle(8);
    check("t6_wr_cnt", 64'(wr_cnt - w0), 64'd4);
    check("t6_ww4", 64'(words_written), 64'd4);
    check("t6_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) pix(16'(16'h00D0 + i), 1'b0, i == 3);
    wait_done(snap, "t6");
    check("t6_ww6", 64'(words_written), 64'd6);
    check("t6_ovf_sticky", 64'(overflow), 64'd1);

    // reset while a write is pending
    do_start(13'h0500, 14'd8);
    check("t7_ovf_cleared", 64'(overflow), 64'd0);
    avm.avm_waitrequest = 1'b1;
    exp_add(13'h0500, 4'hF, 32'h00E1_00E0);
    exp_add(13'h0501, 4'hF, 32'h00E3_00E2);
    for (int i = 0; i < 4; i++) pix(16'(16'h00E0 + i), i == 0, 1'b0);
    check("t7_wr_pending", 64'(avm.avm_write), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_write", 64'(avm.avm_write), 64'd0);
    check("t7_rst_cs", 64'(avm.avm_chipselect), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    avm.avm_waitrequest = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) pix(16'(16'h00F0 + i), i == 0, i == 5);
    idle(4);
    check("t7_no_wr_after_rst", 64'(wr_cnt - w0), 64'd0);
    check("t7_idle_busy", 64'(busy), 64'd0);
    snap = done_cnt;
    do_start(13'h0510, 14'd1);
    exp_add(13'h0510, 4'hF, 32'h0222_0111);
    pix(16'h0111, 1'b1, 1'b0);
    pix(16'h0222, 1'b0, 1'b1);
    wait_done(snap, "t7");
    check("t7_ww", 64'(words_written), 64'd1);
    check("t7_wr_cnt", 64'(wr_cnt - w0), 64'd1);

    idle(3);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
